mux_nx1_scan: RTL and testbench

//   Parametrised registered N-channel, W-bit multiplexer, next generation of the 4x1 mux.
//   Two modes: MANUAL (external select) and SCAN (auto round-robin, fixed dwell per channel).

---
 rtl/mux_nx1_scan.sv | 181 ++++++++++++++++++
 tb/tb_mux_nx1_scan.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/mux_nx1_scan.sv
// rtl/mux_nx1_scan.sv - registered N-channel mux, manual select or round-robin scan (option: MUX_SCAN_MASK_EN)
module mux_nx1_scan #(
  parameter int WIDTH = 4,
  parameter int N_CH  = 4,
  parameter int SEL_W = 2,
  parameter int DWELL = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [N_CH*WIDTH-1:0] in_bus,
  input  logic [SEL_W-1:0]      sel,
  input  logic                  modo,
  input  logic                  enable,
`ifdef MUX_SCAN_MASK_EN
  input  logic [N_CH-1:0]       ch_mask,
`endif
  output logic [WIDTH-1:0]      out,
  output logic [SEL_W-1:0]      out_ch,
  output logic                  out_valid,
  output logic                  scan_wrap
);

  localparam int              DW_W       = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL - 1);

  typedef enum logic [1:0] {IDLE, MANUAL, SCAN} state_t;

  state_t           state, state_nxt;
  logic [SEL_W-1:0] idx, idx_nxt;
  logic [DW_W-1:0]  dwell, dwell_nxt;
  logic [WIDTH-1:0] out_nxt;
  logic [SEL_W-1:0] out_ch_nxt;
  logic             out_valid_nxt;
  logic             scan_wrap_nxt;

  // Channel k of the packed bus; indices beyond the last channel read as zero.
  function automatic logic [WIDTH-1:0] pick(input logic [N_CH*WIDTH-1:0] bus,
                                            input logic [SEL_W-1:0] k);
    pick = '0;
    for (int c = 0; c < N_CH; c++)
      if (int'(k) == c) pick = bus[c*WIDTH +: WIDTH];
  endfunction

`ifdef MUX_SCAN_MASK_EN
  // Lowest enabled channel, used as the scan starting point.
  function automatic logic [SEL_W-1:0] first_set(input logic [N_CH-1:0] m);
    first_set = '0;
    for (int c = N_CH - 1; c >= 0; c--)
      if (m[c]) first_set = SEL_W'(c);
  endfunction

  // Next enabled channel after cur (circular); MSB flags that the search passed index 0.
  function automatic logic [SEL_W:0] next_set(input logic [SEL_W-1:0] cur,
                                              input logic [N_CH-1:0]  m);
    logic             found;
    logic [SEL_W-1:0] n;
    logic             w;
    int               c;
    found = 1'b0;
    n     = cur;
    w     = 1'b0;
    for (int k = 1; k <= N_CH; k++) begin
      c = (int'(cur) + k) % N_CH;
      if (!found && m[c]) begin
        found = 1'b1;
        n     = SEL_W'(c);
        w     = (int'(cur) + k >= N_CH);
      end
    end
    return {w, n};
  endfunction
`endif

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next state: modo picks the mode on every enabled edge, from any state.
  always_comb begin
    state_nxt = state;
    if (enable) state_nxt = modo ? SCAN : MANUAL;
  end

  // Next datapath values; a mode change always overrides a pending scan advance.
  always_comb begin
    idx_nxt       = idx;
    dwell_nxt     = dwell;
    out_nxt       = out;
    out_ch_nxt    = out_ch;
    out_valid_nxt = out_valid;
    scan_wrap_nxt = 1'b0;
    if (enable) begin
      if (!modo) begin
        out_ch_nxt = sel;
        if (int'(sel) < N_CH) begin
          out_nxt       = pick(in_bus, sel);
          out_valid_nxt = 1'b1;
        end else begin
          out_nxt       = '0;
          out_valid_nxt = 1'b0;
        end
      end else if (state != SCAN) begin
        dwell_nxt = '0;
`ifdef MUX_SCAN_MASK_EN
        if (ch_mask == '0) begin
          idx_nxt       = '0;
          out_nxt       = '0;
          out_ch_nxt    = '0;
          out_valid_nxt = 1'b0;
        end else begin
          idx_nxt       = first_set(ch_mask);
          out_nxt       = pick(in_bus, idx_nxt);
          out_ch_nxt    = idx_nxt;
          out_valid_nxt = 1'b1;
        end
`else
        idx_nxt       = '0;
        out_nxt       = pick(in_bus, '0);
        out_ch_nxt    = '0;
        out_valid_nxt = 1'b1;
`endif
      end else begin
`ifdef MUX_SCAN_MASK_EN
        if (ch_mask == '0) begin
          dwell_nxt     = '0;
          out_nxt       = '0;
          out_ch_nxt    = idx;
          out_valid_nxt = 1'b0;
        end else begin
          if (dwell == DWELL_LAST) begin
            dwell_nxt                = '0;
            {scan_wrap_nxt, idx_nxt} = next_set(idx, ch_mask);
          end else begin
            dwell_nxt = dwell + DW_W'(1);
          end
          out_nxt       = pick(in_bus, idx_nxt);
          out_ch_nxt    = idx_nxt;
          out_valid_nxt = 1'b1;
        end
`else
        if (dwell == DWELL_LAST) begin
          dwell_nxt = '0;
          if (int'(idx) == N_CH - 1) begin
            idx_nxt       = '0;
            scan_wrap_nxt = 1'b1;
          end else begin
            idx_nxt = idx + SEL_W'(1);
          end
        end else begin
          dwell_nxt = dwell + DW_W'(1);
        end
        out_nxt       = pick(in_bus, idx_nxt);
        out_ch_nxt    = idx_nxt;
        out_valid_nxt = 1'b1;
`endif
      end
    end
  end

  // Datapath registers; reset clears everything including any wrap pulse in flight.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      idx       <= '0;
      dwell     <= '0;
      out       <= '0;
      out_ch    <= '0;
      out_valid <= 1'b0;
      scan_wrap <= 1'b0;
    end else begin
      idx       <= idx_nxt;
      dwell     <= dwell_nxt;
      out       <= out_nxt;
      out_ch    <= out_ch_nxt;
      out_valid <= out_valid_nxt;
      scan_wrap <= scan_wrap_nxt;
    end
  end

endmodule

// File: tb/tb_mux_nx1_scan.sv
// tb/tb_mux_nx1_scan.sv - scoreboard bench for mux_nx1_scan (4ch/dwell 4 and 3ch/dwell 1 instances)
module tb_mux_nx1_scan;

  typedef struct {
    logic [3:0] out;
    logic [1:0] ch;
    logic       valid;
    logic       wrap;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [15:0] in_bus;
  logic [1:0]  sel;
  logic        modo;
  logic        enable;

  logic [3:0] out4, out3;
  logic [1:0] ch4, ch3;
  logic       v4, v3, w4, w3;

  int checks = 0;
  int errors = 0;

  exp_t q4[$];
  exp_t q3[$];

  // Reference model: position in scan is a plain tick count since scan entry.
  int   n_ch[2]  = '{4, 3};
  int   dwl[2]   = '{4, 1};
  int   m_mode[2];
  int   m_t[2];
  exp_t m_last[2];

  always #5 clock = ~clock;

  mux_nx1_scan #(.WIDTH(4), .N_CH(4), .SEL_W(2), .DWELL(4)) dut4 (
    .clock(clock), .reset_n(reset_n), .in_bus(in_bus), .sel(sel), .modo(modo),
    .enable(enable), .out(out4), .out_ch(ch4), .out_valid(v4), .scan_wrap(w4)
  );

  mux_nx1_scan #(.WIDTH(4), .N_CH(3), .SEL_W(2), .DWELL(1)) dut3 (
    .clock(clock), .reset_n(reset_n), .in_bus(in_bus[11:0]), .sel(sel), .modo(modo),
    .enable(enable), .out(out3), .out_ch(ch3), .out_valid(v3), .scan_wrap(w3)
  );

  function automatic logic [3:0] chan(input int c);
    return in_bus[c*4 +: 4];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_mode[i] = 0;
      m_t[i]    = 0;
      m_last[i] = '{out: 4'h0, ch: 2'd0, valid: 1'b0, wrap: 1'b0};
    end
  endtask

  task automatic model_edge(input int i, output exp_t e);
    int c;
    e      = m_last[i];
    e.wrap = 1'b0;
    if (enable) begin
      if (!modo) begin
        m_mode[i] = 1;
        e.ch      = sel;
        e.valid   = (int'(sel) < n_ch[i]);
        e.out     = e.valid ? chan(int'(sel)) : 4'h0;
      end else begin
        if (m_mode[i] != 2) begin
          m_mode[i] = 2;
          m_t[i]    = 0;
        end else begin
          m_t[i]++;
        end
        c       = (m_t[i] / dwl[i]) % n_ch[i];
        e.wrap  = (m_t[i] > 0) && (m_t[i] % (dwl[i] * n_ch[i]) == 0);
        e.ch    = 2'(c);
        e.valid = 1'b1;
        e.out   = chan(c);
      end
    end
    m_last[i] = e;
  endtask

  // Predict both instances for the next edge, then queue the predictions once it has passed.
  task automatic step();
    exp_t e4, e3;
    model_edge(0, e4);
    model_edge(1, e3);
    @(posedge clock);
    q4.push_back(e4);
    q3.push_back(e3);
    #1;
  endtask

  task automatic check_zero(input string name);
    checks++;
    if (out4 !== 4'h0 || ch4 !== 2'd0 || v4 !== 1'b0 || w4 !== 1'b0) begin
      errors++;
      $display("FAIL %s dut4: got out=%h ch=%0d valid=%b wrap=%b, want all zero",
               name, out4, ch4, v4, w4);
    end
    checks++;
    if (out3 !== 4'h0 || ch3 !== 2'd0 || v3 !== 1'b0 || w3 !== 1'b0) begin
      errors++;
      $display("FAIL %s dut3: got out=%h ch=%0d valid=%b wrap=%b, want all zero",
               name, out3, ch3, v3, w3);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    #1;
    reset_n = 1'b0;
    #1;
    check_zero("reset_async");
    model_reset();
    @(negedge clock);
    #1;
    check_zero("reset_hold");
    reset_n = 1'b1;
  endtask

  // Monitor: every output cycle consumes one queued prediction per instance.
  always @(negedge clock) begin
    exp_t e;
    if (q4.size() > 0) begin
      e = q4.pop_front();
      checks++;
      if (out4 !== e.out || ch4 !== e.ch || v4 !== e.valid || w4 !== e.wrap) begin
        errors++;
        $display("FAIL dut4 @%0t: got out=%h ch=%0d valid=%b wrap=%b, want out=%h ch=%0d valid=%b wrap=%b",
                 $time, out4, ch4, v4, w4, e.out, e.ch, e.valid, e.wrap);
      end
    end
    if (q3.size() > 0) begin
      e = q3.pop_front();
      checks++;
      if (out3 !== e.out || ch3 !== e.ch || v3 !== e.valid || w3 !== e.wrap) begin
        errors++;
        $display("FAIL dut3 @%0t: got out=%h ch=%0d valid=%b wrap=%b, want out=%h ch=%0d valid=%b wrap=%b",
                 $time, out3, ch3, v3, w3, e.out, e.ch, e.valid, e.wrap);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    in_bus  = 16'h0;
    sel     = 2'd0;
    modo    = 1'b0;
    enable  = 1'b0;
    model_reset();
    #2;
    check_zero("reset_init");
    @(negedge clock);
    #1;
    reset_n = 1'b1;

    // Disabled from reset: everything holds at zero.
    repeat (2) step();

    // Manual select, including an illegal select on the 3-channel instance.
    enable = 1'b1;
    in_bus = 16'hA5C3;
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      step();
    end
    sel = 2'd2;
    step();
    sel = 2'd3;
    step();

    // Scan with live input changes and a 5-cycle enable pause mid-dwell.
    modo = 1'b1;
    repeat (6) begin
      in_bus = 16'($urandom);
      step();
    end
    enable = 1'b0;
    repeat (5) begin
      in_bus = 16'($urandom);
      step();
    end
    enable = 1'b1;
    repeat (40) begin
      in_bus = 16'($urandom);
      step();
    end

    // Reset while scanning channel 2 of the 4-channel instance.
    modo = 1'b0;
    step();
    modo = 1'b1;
    repeat (10) step();
    do_reset();

    // Mode race: leave scan exactly on the terminal dwell of the last channel.
    modo = 1'b1;
    repeat (16) step();
    modo = 1'b0;
    sel  = 2'd1;
    in_bus = 16'h7E29;
    step();
    step();

    // Randomised mix of modes, selects, enables and data.
    repeat (500) begin
      in_bus = 16'($urandom);
      sel    = 2'($urandom_range(0, 3));
      enable = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 7) == 0) modo = ~modo;
      step();
    end

    @(negedge clock);
    #1;
    checks++;
    if (q4.size() != 0 || q3.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d/%0d pending predictions, want 0/0", q4.size(), q3.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
